// File: rtl/rv_iopmp_entry_reader.sv
// rv_iopmp_entry_reader: walks an inclusive index range of the entry BRAM and streams
// each 128-bit entry out over valid/ready through a 2-deep buffer.
module rv_iopmp_entry_reader #(
    parameter int NUMBER_ENTRIES = 8,
    parameter int IW = $clog2(NUMBER_ENTRIES)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic [IW-1:0] req_first_i,
    input  logic [IW-1:0] req_last_i,
    input  logic          abort_i,
    output logic          err_o,
    output logic          entry_valid_o,
    input  logic          entry_ready_i,
    output logic [127:0]  entry_o,
    output logic [IW-1:0] entry_idx_o,
    output logic          entry_last_o,
    output logic          en_bram_o,
    output logic [IW-1:0] addr_bram_o,
    input  logic [127:0]  dout_bram_i
);
    localparam int DW = 128 + IW + 1;
    typedef enum logic [1:0] {IDLE, WALK, DRAIN} state_t;
    state_t state, state_nxt;
    logic [IW-1:0] next_idx, last_idx, addr_q, tag_idx;
    logic tag_last, inflight, err_q, accept, bad, issue, pop, push;
    logic [1:0] count, count_nxt, kept;
    logic [DW-1:0] slot0, slot1;
    assign accept = req_valid_i && req_ready_o;
    assign bad = (req_first_i > req_last_i) || ({1'b0, req_last_i} >= (IW+1)'(NUMBER_ENTRIES));
    assign pop = entry_valid_o && entry_ready_i;
    assign push = inflight && !abort_i;
    assign kept = count - {1'b0, pop};
    assign count_nxt = kept + {1'b0, push};
    // Buffered plus in-flight reads may never exceed the two buffer slots.
    assign issue = (state == WALK) && !abort_i &&
                   (({1'b0, count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));
    assign err_o = err_q;
    assign entry_valid_o = count != 2'd0;
    assign entry_o = slot0[DW-1 -: 128];
    assign entry_idx_o = slot0[IW:1];
    assign entry_last_o = slot0[0];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = abort_i ? IDLE :
                    (state == IDLE && accept && !bad) ? WALK :
                    (state == WALK && issue && next_idx == last_idx) ? DRAIN :
                    (state == DRAIN && count_nxt == 2'd0 && !inflight) ? IDLE : state;
    end

    always_comb begin
        req_ready_o = (state == IDLE) && !abort_i;
        en_bram_o = issue;
        addr_bram_o = issue ? next_idx : addr_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count <= 2'd0;
            inflight <= 1'b0;
            err_q <= 1'b0;
            next_idx <= '0;
            last_idx <= '0;
            addr_q <= '0;
            tag_idx <= '0;
            tag_last <= 1'b0;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            err_q <= accept && bad;
            inflight <= issue;
            count <= abort_i ? 2'd0 : count_nxt;
            if (accept) begin
                next_idx <= req_first_i;
                last_idx <= req_last_i;
            end
            if (issue) begin
                next_idx <= next_idx + IW'(1);
                addr_q <= next_idx;
                tag_idx <= next_idx;
                tag_last <= next_idx == last_idx;
            end
            if (pop && count == 2'd2) slot0 <= slot1;
            if (push && kept == 2'd0) slot0 <= {dout_bram_i, tag_idx, tag_last};
            if (push && kept != 2'd0) slot1 <= {dout_bram_i, tag_idx, tag_last};
        end
    end
endmodule
